// File: rtl/prbs7_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : prbs7_word_gen
// Purpose  : 64-bit-per-clock PRBS7 (x^7 + x^6 + 1) pattern source for the
//            serializer/loopback path. Supports a programmable seed,
//            a 0..63 bit misalignment across word boundaries, and
//            deterministic single-shot and periodic error injection.
// Ports    :
//    clk         in   clock
//    reset       in   synchronous, active-high reset
//    enable      in   advance the generator one 64-bit word per cycle
//    seed        in   LFSR seed (all-zero is replaced by 7'h7F)
//    seed_load   in   pulse: reload LFSR from seed and flush the pipeline
//    bit_shift   in   output rotation (misalignment) in bits
//    inj_mask    in   XOR mask applied to an injected word
//    inj_single  in   pulse: request one injection
//    inj_period  in   periodic injection interval in enabled cycles, 0 = off
//    dout        out  pattern word, dout[0] is earliest bit in time
//    dout_valid  out  dout carries valid pattern
//    inj_active  out  current dout contains injected bits
//    inj_count   out  number of injected words (saturating)
//    lfsr_state  out  current LFSR state
// Revision : 1.0 - initial release
// ============================================================================
module prbs7_word_gen #(
   parameter int CNT_W = 24,
   parameter int PER_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [6:0]       seed,
   input  logic             seed_load,
   input  logic [5:0]       bit_shift,
   input  logic [63:0]      inj_mask,
   input  logic             inj_single,
   input  logic [PER_W-1:0] inj_period,
   output logic [63:0]      dout,
   output logic             dout_valid,
   output logic             inj_active,
   output logic [CNT_W-1:0] inj_count,
   output logic [6:0]       lfsr_state
);

   localparam logic [6:0] C_SEED_ALT = 7'h7F;
   localparam logic [1:0] C_FILL_MAX = 2'd2;

   logic [6:0]       r_lfsr;
   logic [63:0]      r_g;        // newest generated word
   logic [63:0]      r_g_d;      // previous generated word
   logic             r_gi;       // r_g carries injected bits
   logic             r_gi_d;     // r_g_d carries injected bits
   logic [1:0]       r_fill;     // enabled cycles since reset/reload, saturates at 2
   logic [PER_W-1:0] r_cnt;      // periodic injection counter
   logic             r_pending;  // single-shot request waiting for an enabled cycle

   logic [6:0]       w_seed;
   logic [63:0]      w_word;
   logic [6:0]       w_lfsr_next;
   logic             w_hit;
   logic             w_inj;
   logic [127:0]     w_cat_sh;
   logic             w_cnt_sat;

   // All-zero would lock the LFSR, so substitute the all-ones state.
   assign w_seed = (seed == 7'd0) ? C_SEED_ALT : seed;

   // 64 unrolled LFSR steps; bit i of the word is the i-th emitted bit.
   always_comb begin
      logic [6:0] v_s;
      logic       v_nb;
      v_s    = r_lfsr;
      w_word = '0;
      for (int i = 0; i < 64; i++) begin
         v_nb      = v_s[6] ^ v_s[5];
         w_word[i] = v_nb;
         v_s       = {v_s[5:0], v_nb};
      end
      w_lfsr_next = v_s;
   end

   // A counter at or beyond the interval fires on the next enabled cycle,
   // so shrinking inj_period below the current count cannot skip a hit.
   assign w_hit = enable && (inj_period != '0) &&
                  (r_cnt >= (inj_period - {{(PER_W-1){1'b0}}, 1'b1}));

   // A reload cycle generates no word, so it cannot carry an injection.
   assign w_inj = enable && !seed_load && (r_pending || inj_single || w_hit);

   // {g, g_d}[bit_shift +: 64]: older word in the low half.
   assign w_cat_sh  = {r_g, r_g_d} >> bit_shift;
   assign w_cnt_sat = &inj_count;

   assign lfsr_state = r_lfsr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_lfsr     <= w_seed;
         r_g        <= '0;
         r_g_d      <= '0;
         r_gi       <= 1'b0;
         r_gi_d     <= 1'b0;
         dout       <= '0;
         dout_valid <= 1'b0;
         inj_active <= 1'b0;
         r_pending  <= 1'b0;
         inj_count  <= '0;
         r_cnt      <= '0;
         r_fill     <= '0;
      end else if (seed_load) begin
         // Restart the stream; pipeline contents become stale until refilled.
         r_lfsr     <= w_seed;
         r_fill     <= '0;
         dout_valid <= 1'b0;
         r_pending  <= 1'b0;
         r_cnt      <= '0;
      end else begin
         dout_valid <= enable && (r_fill == C_FILL_MAX);

         if (enable) begin
            r_lfsr     <= w_lfsr_next;
            r_g        <= w_word ^ (w_inj ? inj_mask : 64'd0);
            r_gi       <= w_inj;
            r_g_d      <= r_g;
            r_gi_d     <= r_gi;
            dout       <= w_cat_sh[63:0];
            // With a nonzero rotation the newer word also contributes bits.
            inj_active <= r_gi_d || ((bit_shift != 6'd0) && r_gi);

            if (r_fill != C_FILL_MAX)
               r_fill <= r_fill + 2'd1;

            if (inj_period == '0 || w_hit)
               r_cnt <= '0;
            else
               r_cnt <= r_cnt + {{(PER_W-1){1'b0}}, 1'b1};
         end

         // Several requests before consumption collapse into one injection.
         if (w_inj)
            r_pending <= 1'b0;
         else if (inj_single)
            r_pending <= 1'b1;

         if (w_inj && (inj_mask != 64'd0) && !w_cnt_sat)
            inj_count <= inj_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prbs7_word_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs7_word_gen
// Purpose  : Directed self-checking bench for prbs7_word_gen. Expected words
//            come from a bit-serial PRBS7 reference built at time zero.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs7_word_gen;

   localparam int CNT_W = 4;
   localparam int PER_W = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [6:0]       seed;
   logic             seed_load;
   logic [5:0]       bit_shift;
   logic [63:0]      inj_mask;
   logic             inj_single;
   logic [PER_W-1:0] inj_period;
   logic [63:0]      dout;
   logic             dout_valid;
   logic             inj_active;
   logic [CNT_W-1:0] inj_count;
   logic [6:0]       lfsr_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] gold [0:599];
   logic [6:0]  gst  [0:600];

   prbs7_word_gen #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .seed       (seed),
      .seed_load  (seed_load),
      .bit_shift  (bit_shift),
      .inj_mask   (inj_mask),
      .inj_single (inj_single),
      .inj_period (inj_period),
      .dout       (dout),
      .dout_valid (dout_valid),
      .inj_active (inj_active),
      .inj_count  (inj_count),
      .lfsr_state (lfsr_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference from seed 7'h7F: gst[i] is the state after i words.
   task automatic build_gold();
      logic [6:0]  s;
      logic [63:0] w;
      logic        nb;
      s = 7'h7F;
      gst[0] = s;
      for (int i = 0; i < 600; i++) begin
         w = '0;
         for (int b = 0; b < 64; b++) begin
            nb   = s[6] ^ s[5];
            w[b] = nb;
            s    = {s[5:0], nb};
         end
         gold[i]  = w;
         gst[i+1] = s;
      end
   endtask

   initial begin
      int          k;
      int          en;
      logic [63:0] exp_w;

      reset = 1'b1; enable = 1'b0; seed = 7'h7F; seed_load = 1'b0;
      bit_shift = '0; inj_mask = '0; inj_single = 1'b0; inj_period = '0;
      build_gold();
      step(); step();

      // Reset state
      check("rst_dout",  dout, 64'd0);
      check("rst_valid", 64'(dout_valid), 64'd0);
      check("rst_inj",   64'(inj_active), 64'd0);
      check("rst_cnt",   64'(inj_count), 64'd0);
      check("rst_lfsr",  64'(lfsr_state), 64'h7F);

      // Free-running stream, valid from the third enabled edge
      reset = 1'b0; enable = 1'b1;
      step();
      check("fill1_valid", 64'(dout_valid), 64'd0);
      check("fill1_lfsr",  64'(lfsr_state), 64'(gst[1]));
      step();
      check("fill2_valid", 64'(dout_valid), 64'd0);
      step();
      check("first_valid", 64'(dout_valid), 64'd1);
      check("first_byte",  64'(dout[7:0]), 64'h40);
      check("first_word",  dout, gold[0]);
      check("first_lfsr",  64'(lfsr_state), 64'(gst[3]));
      for (k = 1; k < 500; k++) begin
         step();
         check($sformatf("stream_w%0d", k), dout, gold[k]);
         check($sformatf("stream_v%0d", k), 64'(dout_valid), 64'd1);
      end
      k = 499;

      // Random enable toggling: disabled cycles hold everything but valid
      for (int i = 0; i < 40; i++) begin
         en = int'($urandom_range(0, 1));
         enable = en[0];
         step();
         if (en != 0) k++;
         check($sformatf("tog_w%0d", i), dout, gold[k]);
         check($sformatf("tog_v%0d", i), 64'(dout_valid), 64'(en));
         check($sformatf("tog_l%0d", i), 64'(lfsr_state), 64'(gst[k+3]));
      end

      // Zero seed reload behaves as 7'h7F
      enable = 1'b1; seed = 7'h00; seed_load = 1'b1;
      step();
      check("zseed_lfsr",  64'(lfsr_state), 64'h7F);
      check("zseed_valid", 64'(dout_valid), 64'd0);
      seed_load = 1'b0;
      step();
      check("zseed_f1", 64'(dout_valid), 64'd0);
      step();
      check("zseed_f2", 64'(dout_valid), 64'd0);
      step();
      check("zseed_v0", 64'(dout_valid), 64'd1);
      check("zseed_w0", dout, gold[0]);
      for (k = 1; k < 5; k++) begin
         step();
         check($sformatf("zseed_w%0d", k), dout, gold[k]);
      end

      // Misalignment by 5 bits, switched mid-stream without a valid drop
      bit_shift = 6'd5;
      for (k = 5; k < 20; k++) begin
         step();
         check($sformatf("sh5_v%0d", k),  64'(dout_valid), 64'd1);
         check($sformatf("sh5_lo%0d", k), 64'(dout[58:0]), 64'(gold[k][63:5]));
         check($sformatf("sh5_hi%0d", k), 64'(dout[63:59]), 64'(gold[k+1][4:0]));
      end
      bit_shift = 6'd0;

      // Periodic injection every 10th word in bit 0
      seed = 7'h7F; inj_mask = 64'h1; inj_period = 16'd10; seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      step(); step();
      for (k = 0; k < 100; k++) begin
         step();
         exp_w = gold[k] ^ ((k % 10 == 9) ? 64'h1 : 64'h0);
         check($sformatf("per_w%0d", k), dout, exp_w);
         check($sformatf("per_a%0d", k), 64'(inj_active), 64'((k % 10) == 9));
      end
      check("per_count", 64'(inj_count), 64'd10);

      // Single-shot requested twice while disabled: exactly one injection
      inj_period = '0; inj_mask = 64'hF0; seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      step(); step(); step();
      check("ss_pre", dout, gold[0]);
      enable = 1'b0;
      inj_single = 1'b1; step();
      inj_single = 1'b0; step();
      inj_single = 1'b1; step();
      inj_single = 1'b0; step();
      step();
      check("ss_hold_valid", 64'(dout_valid), 64'd0);
      check("ss_hold_cnt",   64'(inj_count), 64'd10);
      check("ss_hold_dout",  dout, gold[0]);
      enable = 1'b1;
      for (k = 1; k < 7; k++) begin
         step();
         exp_w = gold[k] ^ ((k == 3) ? 64'hF0 : 64'h0);
         check($sformatf("ss_w%0d", k), dout, exp_w);
         check($sformatf("ss_a%0d", k), 64'(inj_active), 64'(k == 3));
      end
      check("ss_count", 64'(inj_count), 64'd11);

      // Single-shot coinciding with a periodic hit: mask once, counted once
      inj_period = 16'd4; inj_mask = 64'h8000_0000_0000_0001; seed_load = 1'b1;
      step();
      seed_load = 1'b0;
      step(); step(); step();
      inj_single = 1'b1;
      step();
      inj_single = 1'b0;
      check("both_count", 64'(inj_count), 64'd12);
      step(); step();
      check("both_w3", dout, gold[3] ^ 64'h8000_0000_0000_0001);
      check("both_a3", 64'(inj_active), 64'd1);
      step();
      check("both_w4", dout, gold[4]);
      check("both_a4", 64'(inj_active), 64'd0);

      // Counter saturates at all-ones
      inj_period = 16'd1;
      repeat (5) step();
      check("sat_count", 64'(inj_count), 64'hF);

      // Reset mid-stream with enable held high, then restart from seed
      reset = 1'b1;
      step();
      check("mrst_dout",  dout, 64'd0);
      check("mrst_valid", 64'(dout_valid), 64'd0);
      check("mrst_inj",   64'(inj_active), 64'd0);
      check("mrst_cnt",   64'(inj_count), 64'd0);
      check("mrst_lfsr",  64'(lfsr_state), 64'h7F);
      reset = 1'b0; inj_period = '0; inj_mask = '0;
      step();
      check("mrst_f1", 64'(dout_valid), 64'd0);
      step(); step();
      check("mrst_v0", 64'(dout_valid), 64'd1);
      check("mrst_w0", dout, gold[0]);
      step();
      check("mrst_w1", dout, gold[1]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
